// File: rtl/addsub_sliced_if.sv
// addsub_sliced_if: command/result bundle for the sliced adder/subtractor.
//   master : issues commands (in_valid, i0, i1, cin, sub) and accepts results
//            (out_ready); observes in_ready, out_valid, o, cout, v.
//   slave  : the arithmetic block itself, the mirror image of master.
interface addsub_sliced_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic             cout;
    logic             v;

    modport master (
        output in_valid, i0, i1, cin, sub, out_ready,
        input  in_ready, out_valid, o, cout, v
    );

    modport slave (
        input  in_valid, i0, i1, cin, sub, out_ready,
        output in_ready, out_valid, o, cout, v
    );
endinterface

// File: rtl/addsub_sliced.sv
// addsub_sliced: multi-cycle WIDTH-bit adder/subtractor that pushes SLICE bits
// per clock through a single SLICE-bit carry chain, registering the carry
// between slices.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : slave side of addsub_sliced_if
//              in_valid/in_ready handshake with i0, i1, cin, sub
//              out_valid/out_ready handshake with o, cout, v
// sub=0: o = i0 + i1 + cin. sub=1: o = i0 - i1 - cin (cin acts as borrow-in).
// cout is the adder carry-out (for sub: 1 = no borrow). v is two's-complement
// overflow. A result appears NSLICE edges after the accepting edge and is held
// until out_ready is seen at an edge.
module addsub_sliced #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic           clk,
    input  logic           rst,
    addsub_sliced_if.slave bus
);
    localparam int SLICE_SAFE = (SLICE < 1) ? 1 : SLICE;
    localparam int NSLICE     = WIDTH / SLICE_SAFE;
    localparam int KW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    generate
        if (SLICE < 1) begin : g_bad_slice
            $error("addsub_sliced: SLICE must be >= 1");
        end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
            $error("addsub_sliced: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // One SLICE-bit ripple step: {carry_out, sum}.
    function automatic logic [SLICE_SAFE:0] slice_add(
        input logic [SLICE_SAFE-1:0] x,
        input logic [SLICE_SAFE-1:0] y,
        input logic                  ci
    );
        return {1'b0, x} + {1'b0, y} + {{SLICE_SAFE{1'b0}}, ci};
    endfunction

    // Signed overflow: operands share a sign and the result sign differs.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Operand stage: captured at accept. b_p0 already holds the inverted
    // subtrahend for SUB so the datapath below is always an addition.
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             carry_p0;
    logic [KW-1:0]    k_p0;

    // Result stage.
    logic [WIDTH-1:0] o_p1;
    logic             cout_p1;
    logic             v_p1;

    logic                  accept;
    logic                  last;
    logic [SLICE_SAFE-1:0] a_sl;
    logic [SLICE_SAFE-1:0] b_sl;
    logic [SLICE_SAFE:0]   sum;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (k_p0 == K_LAST);

    always_comb begin
        a_sl = a_p0[k_p0*SLICE_SAFE +: SLICE_SAFE];
        b_sl = b_p0[k_p0*SLICE_SAFE +: SLICE_SAFE];
        sum  = slice_add(a_sl, b_sl, carry_p0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                // Held low during reset so a command presented alongside reset
                // is never handshaken.
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at accept (accept is already gated by reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= bus.i0;
            b_p0 <= bus.sub ? ~bus.i1 : bus.i1;
        end
    end

    // Slice engine: one SLICE-bit addition per BUSY edge, LSB slice first.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_p0 <= 1'b0;
            k_p0     <= '0;
            o_p1     <= '0;
            cout_p1  <= 1'b0;
            v_p1     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtraction is A + ~B + 1; a borrow-in removes the +1.
                        carry_p0 <= bus.cin ^ bus.sub;
                        k_p0     <= '0;
                    end
                end
                BUSY: begin
                    o_p1[k_p0*SLICE_SAFE +: SLICE_SAFE] <= sum[SLICE_SAFE-1:0];
                    carry_p0 <= sum[SLICE_SAFE];
                    k_p0     <= k_p0 + 1'b1;
                    if (last) begin
                        cout_p1 <= sum[SLICE_SAFE];
                        v_p1    <= signed_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1],
                                              sum[SLICE_SAFE-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o    = o_p1;
    assign bus.cout = cout_p1;
    assign bus.v    = v_p1;
endmodule

// File: tb/tb_addsub_sliced.sv
// tb_addsub_sliced: randomized self-checking bench for addsub_sliced
// (WIDTH=16 with SLICE=4, plus a SLICE=16 instance for the single-slice case).
module tb_addsub_sliced;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    addsub_sliced_if #(.WIDTH(16)) bus ();
    addsub_sliced_if #(.WIDTH(16)) bus16 ();

    addsub_sliced #(.WIDTH(16), .SLICE(4))  dut   (.clk(clk), .rst(rst), .bus(bus));
    addsub_sliced #(.WIDTH(16), .SLICE(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    // Reference: whole-word integer arithmetic, signed range test for v.
    function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                      input logic ci, input logic s,
                                      output logic [15:0] ro, output logic rco,
                                      output logic rv);
        int ua, ub, sa, sb, c, u, r;
        ua = {16'b0, a};
        ub = {16'b0, b};
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        c  = ci ? 1 : 0;
        if (!s) begin
            u   = ua + ub + c;
            rco = (u > 65535);
            r   = sa + sb + c;
        end else begin
            u   = ua - ub - c;
            rco = (ua >= ub + c);
            r   = sa - sb - c;
        end
        ro = u[15:0];
        rv = (r > 32767) || (r < -32768);
    endfunction

    // Issue one command on the SLICE=4 instance and wait (bounded) for its result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic s, input bit release_it,
                          output logic [15:0] ro, output logic rco, output logic rv,
                          output int lat);
        @(negedge clk);
        bus.i0 = a; bus.i1 = b; bus.cin = ci; bus.sub = s; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ro = bus.o; rco = bus.cout; rv = bus.v;
        if (release_it) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
        end
        total++;
        if ({bus.out_valid, bus.o, bus.cout, bus.v} !== 19'd0) begin
            bad++; $display("FAIL reset_outputs got=%b/%h/%b/%b want=0/0000/0/0",
                            bus.out_valid, bus.o, bus.cout, bus.v);
        end
        total++;
        if (bus16.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid16 got=%b want=0", bus16.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [4] = '{16'h1234, 16'h0005, 16'h8000, 16'hFFFF};
        logic [15:0] tb [4] = '{16'h0FF0, 16'h0007, 16'h0001, 16'h0000};
        logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [17:0] te [4] = '{{16'h2224, 2'b00}, {16'hFFFE, 2'b00},
                                {16'h7FFE, 2'b11}, {16'h0000, 2'b10}};
        logic [15:0] o;
        logic        co, vv;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], tc[i], ts[i], 1'b1, o, co, vv, lat);
            total++;
            if (lat !== 4) begin
                bad++; $display("FAIL directed%0d_latency got=%0d want=4", i, lat);
            end
            total++;
            if ({o, co, vv} !== te[i]) begin
                bad++; $display("FAIL directed%0d_result got=%h/%b/%b want=%h/%b/%b",
                                i, o, co, vv, te[i][17:2], te[i][1], te[i][0]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, o, eo;
        logic        ci, s, co, vv, eco, ev;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (i % 8 == 0) b = a;
            ci = 1'($urandom);
            s  = 1'($urandom);
            ref_model(a, b, ci, s, eo, eco, ev);
            run_op(a, b, ci, s, 1'b1, o, co, vv, lat);
            total++;
            if (lat !== 4 || {o, co, vv} !== {eo, eco, ev}) begin
                bad++;
                $display("FAIL random%0d a=%h b=%h cin=%b sub=%b got=%h/%b/%b lat=%0d want=%h/%b/%b lat=4",
                         i, a, b, ci, s, o, co, vv, lat, eo, eco, ev);
            end
        end
    endtask

    task automatic test_hold();
        logic [15:0] a, b, o, eo;
        logic        co, vv, eco, ev;
        int          lat, seen;
        a = 16'h7FF0; b = 16'h0123;
        ref_model(a, b, 1'b1, 1'b0, eo, eco, ev);
        run_op(a, b, 1'b1, 1'b0, 1'b0, o, co, vv, lat);
        total++;
        if ({o, co, vv} !== {eo, eco, ev}) begin
            bad++; $display("FAIL hold_result got=%h/%b/%b want=%h/%b/%b", o, co, vv, eo, eco, ev);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.i0 = 16'($urandom); bus.i1 = 16'($urandom);
            bus.cin = 1'($urandom); bus.sub = 1'($urandom);
            @(posedge clk);
            #1;
            total++;
            if ({bus.out_valid, bus.in_ready, bus.o, bus.cout, bus.v} !== {2'b10, eo, eco, ev}) begin
                bad++; $display("FAIL hold_cycle%0d got ov=%b ir=%b %h/%b/%b want ov=1 ir=0 %h/%b/%b",
                                i, bus.out_valid, bus.in_ready, bus.o, bus.cout, bus.v, eo, eco, ev);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++; $display("FAIL hold_release got ov=%b ir=%b want ov=0 ir=1",
                            bus.out_valid, bus.in_ready);
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL hold_no_accept got=%0d results want=0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        bus.i0 = 16'h1234; bus.i1 = 16'h0FF0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.i0 = 16'hAAAA; bus.i1 = 16'h5555;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL midreset_out_valid got=%b want=0", bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.o, bus.cout, bus.v} !== {2'b10, 18'd0}) begin
            bad++; $display("FAIL midreset_after got ir=%b ov=%b %h/%b/%b want ir=1 ov=0 0000/0/0",
                            bus.in_ready, bus.out_valid, bus.o, bus.cout, bus.v);
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL midreset_dropped got=%0d results want=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] q[$];
        logic [17:0] e;
        logic [15:0] eo;
        logic        eco, ev;
        int          last_cyc, results;
        last_cyc = -1;
        results  = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            bus.in_valid = (cyc < 66);
            bus.i0 = 16'($urandom); bus.i1 = 16'($urandom);
            bus.cin = 1'($urandom); bus.sub = 1'($urandom);
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                ref_model(bus.i0, bus.i1, bus.cin, bus.sub, eo, eco, ev);
                q.push_back({eo, eco, ev});
            end
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                results++;
                e = (q.size() > 0) ? q.pop_front() : 18'bx;
                total++;
                if ({bus.o, bus.cout, bus.v} !== e) begin
                    bad++; $display("FAIL b2b_result%0d got=%h/%b/%b want=%h/%b/%b",
                                    results, bus.o, bus.cout, bus.v, e[17:2], e[1], e[0]);
                end
                if (last_cyc >= 0) begin
                    total++;
                    if (cyc - last_cyc !== 6) begin
                        bad++; $display("FAIL b2b_interval got=%0d want=6", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++;
        if (q.size() !== 0 || results < 10) begin
            bad++; $display("FAIL b2b_drain got pending=%0d results=%0d want pending=0 results>=10",
                            q.size(), results);
        end
    endtask

    task automatic test_slice16();
        logic [15:0] a, b, eo;
        logic        ci, s, eco, ev;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                a = 16'h1234; b = 16'h0FF0; ci = 1'b0; s = 1'b0;
            end else begin
                a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); s = 1'($urandom);
            end
            ref_model(a, b, ci, s, eo, eco, ev);
            @(negedge clk);
            bus16.i0 = a; bus16.i1 = b; bus16.cin = ci; bus16.sub = s;
            bus16.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus16.in_valid = 1'b0;
            lat = 0;
            while (bus16.out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            total++;
            if (lat !== 1 || {bus16.o, bus16.cout, bus16.v} !== {eo, eco, ev}) begin
                bad++; $display("FAIL slice16_op%0d got=%h/%b/%b lat=%0d want=%h/%b/%b lat=1",
                                i, bus16.o, bus16.cout, bus16.v, lat, eo, eco, ev);
            end
            @(negedge clk);
            bus16.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus16.out_ready = 1'b0;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.i0 = '0; bus.i1 = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.i0 = '0; bus16.i1 = '0; bus16.cin = 1'b0;
        bus16.sub = 1'b0; bus16.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_slice16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
